core_ctrl: RTL and testbench



---
 rtl/core_ctrl_pkg.sv | 84 ++++++++
 rtl/core_ctrl_mem_wait_timer.sv | 38 +++
 rtl/core_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_core_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer.
// Holds the FSM state encoding, the writeback/PC mux encodings, the trap
// cause codes, the instruction-class flag layout and opcode[6:2] class
// constants, plus small helpers for class decoding.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StTrap   = 3'd6
    } ctrl_state_e;

    // wb_sel encodings
    localparam logic [1:0] WbAlu  = 2'd0;
    localparam logic [1:0] WbMem  = 2'd1;
    localparam logic [1:0] WbPc4  = 2'd2;
    localparam logic [1:0] WbImmU = 2'd3;

    // pc_sel encodings
    localparam logic [1:0] PcPlus4 = 2'd0;
    localparam logic [1:0] PcImm   = 2'd1;
    localparam logic [1:0] PcJalr  = 2'd2;

    // trap_cause encodings
    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseIllegal = 2'd1;
    localparam logic [1:0] CauseImemTo  = 2'd2;
    localparam logic [1:0] CauseDmemTo  = 2'd3;

    // Bit positions of the class flags inside a packed class vector
    localparam int unsigned NumClasses = 10;
    localparam int unsigned ClsLoad    = 0;
    localparam int unsigned ClsStore   = 1;
    localparam int unsigned ClsBranch  = 2;
    localparam int unsigned ClsJalr    = 3;
    localparam int unsigned ClsJal     = 4;
    localparam int unsigned ClsLui     = 5;
    localparam int unsigned ClsAuipc   = 6;
    localparam int unsigned ClsOpImm   = 7;
    localparam int unsigned ClsOp      = 8;
    localparam int unsigned ClsSystem  = 9;

    // opcode[6:2] values per instruction class
    localparam logic [4:0] OpcLoad   = 5'b00000;
    localparam logic [4:0] OpcStore  = 5'b01000;
    localparam logic [4:0] OpcBranch = 5'b11000;
    localparam logic [4:0] OpcJalr   = 5'b11001;
    localparam logic [4:0] OpcJal    = 5'b11011;
    localparam logic [4:0] OpcLui    = 5'b01101;
    localparam logic [4:0] OpcAuipc  = 5'b00101;
    localparam logic [4:0] OpcOpImm  = 5'b00100;
    localparam logic [4:0] OpcOp     = 5'b01100;
    localparam logic [4:0] OpcSystem = 5'b11100;

    // One-hot class vector for an opcode[6:2] value; all-zero if unknown.
    function automatic logic [NumClasses-1:0] class_of_opcode(input logic [4:0] opc);
        logic [NumClasses-1:0] cls;
        cls = '0;
        case (opc)
            OpcLoad:   cls[ClsLoad]   = 1'b1;
            OpcStore:  cls[ClsStore]  = 1'b1;
            OpcBranch: cls[ClsBranch] = 1'b1;
            OpcJalr:   cls[ClsJalr]   = 1'b1;
            OpcJal:    cls[ClsJal]    = 1'b1;
            OpcLui:    cls[ClsLui]    = 1'b1;
            OpcAuipc:  cls[ClsAuipc]  = 1'b1;
            OpcOpImm:  cls[ClsOpImm]  = 1'b1;
            OpcOp:     cls[ClsOp]     = 1'b1;
            OpcSystem: cls[ClsSystem] = 1'b1;
            default:   cls = '0;
        endcase
        return cls;
    endfunction

    // Exactly one bit set.
    function automatic logic is_onehot(input logic [NumClasses-1:0] v);
        return (v != '0) && ((v & (v - {{(NumClasses-1){1'b0}}, 1'b1})) == '0);
    endfunction

endpackage

// File: rtl/core_ctrl_mem_wait_timer.sv
// Wait timer for memory handshakes. Counts cycles spent waiting while
// enabled; expired_o is high in the cycle where the wait has lasted Limit
// cycles (count == Limit-1). clr_i has priority and returns the count to 0.
// Ports: clk_i, rst_ni (async, active-low), clr_i, en_i, expired_o.
module core_ctrl_mem_wait_timer #(
    parameter int unsigned Limit = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LastCount = 8'(Limit - 1);

    logic [7:0] count_q, count_d;

    assign expired_o = (count_q == LastCount);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle control sequencer for an RV32I core, one instruction in flight.
// Ports: clk/rst_n (async active-low); imem_req/imem_ack/ir_we fetch
// handshake; ten decoded class flags; br_taken; dmem_req/dmem_we/dmem_ack
// data handshake; alu_a_sel/alu_b_sel operand selects; rf_we/wb_sel
// writeback; pc_we/pc_sel PC update; halted/trap/trap_cause sticky status;
// retire one pulse per completed instruction.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_we,
    input  logic       load,
    input  logic       store,
    input  logic       branch,
    input  logic       jalr,
    input  logic       jal,
    input  logic       lui,
    input  logic       auipc,
    input  logic       op_imm,
    input  logic       op,
    input  logic       system,
    input  logic       br_taken,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       halted,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       retire
);

    ctrl_state_e           state_q, state_d;
    logic [1:0]            cause_q, cause_d;
    logic [NumClasses-1:0] cls;
    logic                  tmr_en, tmr_clr, tmr_expired;

    assign cls = {system, op, op_imm, auipc, lui, jal, jalr, branch, store, load};

    // Timer only runs while waiting on a memory; any completed handshake or
    // other state restarts it from zero.
    assign tmr_en  = (state_q == StFetch) || (state_q == StMem);
    assign tmr_clr = !tmr_en || ((state_q == StFetch) && imem_ack)
                             || ((state_q == StMem) && dmem_ack);

    core_ctrl_mem_wait_timer #(
        .Limit (MEM_TIMEOUT)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = WbAlu;
        pc_we      = 1'b0;
        pc_sel     = PcPlus4;
        halted     = 1'b0;
        trap       = 1'b0;
        trap_cause = CauseNone;
        retire     = 1'b0;

        // Outputs stay quiet for as long as reset is held.
        if (rst_n) begin
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = StDecode;
                    end else if (tmr_expired) begin
                        state_d = StTrap;
                        cause_d = CauseImemTo;
                    end
                end
                StDecode: begin
                    if (!is_onehot(cls)) begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end else if (system) begin
                        state_d = StHalt;
                    end else begin
                        state_d = StExec;
                    end
                end
                StExec: begin
                    alu_a_sel = auipc | jal;
                    alu_b_sel = op_imm | auipc | jal | jalr | load | store;
                    if (branch) begin
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? PcImm : PcPlus4;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else if (load || store) begin
                        state_d = StMem;
                    end else begin
                        state_d = StWb;
                    end
                end
                StMem: begin
                    dmem_req  = 1'b1;
                    dmem_we   = store;
                    alu_b_sel = 1'b1;
                    if (dmem_ack) begin
                        if (store) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = StFetch;
                        end else begin
                            state_d = StWb;
                        end
                    end else if (tmr_expired) begin
                        state_d = StTrap;
                        cause_d = CauseDmemTo;
                    end
                end
                StWb: begin
                    rf_we   = 1'b1;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = StFetch;
                    if (load) begin
                        wb_sel = WbMem;
                    end else if (jal || jalr) begin
                        wb_sel = WbPc4;
                    end else if (lui) begin
                        wb_sel = WbImmU;
                    end
                    if (jal) begin
                        pc_sel = PcImm;
                    end else if (jalr) begin
                        pc_sel = PcJalr;
                    end
                end
                StHalt: begin
                    halted = 1'b1;
                end
                StTrap: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cause_q <= CauseNone;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
module tb_core_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       br_taken = 1'b0;
    logic [9:0] flags = '0;

    logic       imem_req, ir_we, dmem_req, dmem_we, alu_a_sel, alu_b_sel, rf_we;
    logic       pc_we, halted, trap, retire;
    logic [1:0] wb_sel, pc_sel, trap_cause;

    int n_checks = 0;
    int n_errors = 0;

    // Class flag vector layout: {system, op, op_imm, auipc, lui, jal, jalr, branch, store, load}
    localparam logic [9:0] FLoad   = 10'b0000000001;
    localparam logic [9:0] FStore  = 10'b0000000010;
    localparam logic [9:0] FBranch = 10'b0000000100;
    localparam logic [9:0] FJalr   = 10'b0000001000;
    localparam logic [9:0] FJal    = 10'b0000010000;
    localparam logic [9:0] FLui    = 10'b0000100000;
    localparam logic [9:0] FAuipc  = 10'b0001000000;
    localparam logic [9:0] FOpImm  = 10'b0010000000;
    localparam logic [9:0] FOp     = 10'b0100000000;
    localparam logic [9:0] FSystem = 10'b1000000000;

    // Packed snapshot of all outputs; expected values are built from these masks.
    logic [16:0] outs;
    logic [16:0] exp;
    assign outs = {imem_req, ir_we, dmem_req, dmem_we, alu_a_sel, alu_b_sel, rf_we, wb_sel,
                   pc_we, pc_sel, halted, trap, trap_cause, retire};

    localparam logic [16:0] OImemReq = 17'h10000;
    localparam logic [16:0] OIrWe    = 17'h08000;
    localparam logic [16:0] ODmemReq = 17'h04000;
    localparam logic [16:0] ODmemWe  = 17'h02000;
    localparam logic [16:0] OA       = 17'h01000;
    localparam logic [16:0] OB       = 17'h00800;
    localparam logic [16:0] ORfWe    = 17'h00400;
    localparam logic [16:0] OPcWe    = 17'h00080;
    localparam logic [16:0] OHalted  = 17'h00010;
    localparam logic [16:0] OTrap    = 17'h00008;
    localparam logic [16:0] ORetire  = 17'h00001;
    localparam logic [16:0] OWbRet   = ORfWe | OPcWe | ORetire;

    function automatic logic [16:0] wbs(input logic [1:0] v);
        return {7'd0, v, 8'd0};
    endfunction

    function automatic logic [16:0] pcs(input logic [1:0] v);
        return {10'd0, v, 5'd0};
    endfunction

    function automatic logic [16:0] cau(input logic [1:0] v);
        return {14'd0, v, 1'b0};
    endfunction

    core_ctrl #(
        .MEM_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .ir_we      (ir_we),
        .load       (flags[0]),
        .store      (flags[1]),
        .branch     (flags[2]),
        .jalr       (flags[3]),
        .jal        (flags[4]),
        .lui        (flags[5]),
        .auipc      (flags[6]),
        .op_imm     (flags[7]),
        .op         (flags[8]),
        .system     (flags[9]),
        .br_taken   (br_taken),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .halted     (halted),
        .trap       (trap),
        .trap_cause (trap_cause),
        .retire     (retire)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first FETCH cycle, inputs idle.
    task automatic reset_dut();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        br_taken = 1'b0;
        flags = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    // From a FETCH cycle: ack the fetch, present flags in DECODE, return in EXEC.
    task automatic fetch_and_decode(input logic [9:0] f);
        imem_ack = 1'b1;
        next_cycle();
        imem_ack = 1'b0;
        flags = f;
        next_cycle();
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = '0; #1; n_checks++;
            if (outs !== exp) begin n_errors++; $display("FAIL reset_held[%0d]: got %b expected %b", i, outs, exp); end
            @(posedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1 rst_n = 1'b1;
        exp = OImemReq; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL reset_release: got %b expected %b", outs, exp); end
    endtask

    task automatic test_addi();
        reset_dut();
        imem_ack = 1'b1;
        exp = OImemReq | OIrWe; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL addi_fetch: got %b expected %b", outs, exp); end
        next_cycle();
        flags = FOpImm;          // imem_ack still high: must be ignored in DECODE
        exp = '0; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL addi_decode: got %b expected %b", outs, exp); end
        next_cycle();
        imem_ack = 1'b0;
        dmem_ack = 1'b1;         // must be ignored in EXEC
        exp = OB; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL addi_exec: got %b expected %b", outs, exp); end
        next_cycle();
        dmem_ack = 1'b0;
        exp = OWbRet; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL addi_wb: got %b expected %b", outs, exp); end
        next_cycle();
        exp = OImemReq; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL addi_refetch: got %b expected %b", outs, exp); end
    endtask

    task automatic test_alu_classes();
        logic [9:0]  f_tab   [5];
        logic [16:0] ex_tab  [5];
        logic [16:0] wb_tab  [5];
        f_tab  = '{FOp, FAuipc, FLui, FJal, FJalr};
        ex_tab = '{17'h0, OA | OB, 17'h0, OA | OB, OB};
        wb_tab = '{OWbRet, OWbRet, OWbRet | wbs(2'd3), OWbRet | wbs(2'd2) | pcs(2'd1),
                   OWbRet | wbs(2'd2) | pcs(2'd2)};
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            fetch_and_decode(f_tab[i]);
            exp = ex_tab[i]; #1; n_checks++;
            if (outs !== exp) begin n_errors++; $display("FAIL class_exec[%0d]: got %b expected %b", i, outs, exp); end
            next_cycle();
            exp = wb_tab[i]; #1; n_checks++;
            if (outs !== exp) begin n_errors++; $display("FAIL class_wb[%0d]: got %b expected %b", i, outs, exp); end
            next_cycle();
        end
        exp = OImemReq; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL class_refetch: got %b expected %b", outs, exp); end
    endtask

    task automatic test_branch();
        reset_dut();
        fetch_and_decode(FBranch);
        br_taken = 1'b1;
        exp = OPcWe | pcs(2'd1) | ORetire; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL beq_taken_exec: got %b expected %b", outs, exp); end
        next_cycle();
        br_taken = 1'b0;
        exp = OImemReq; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL beq_taken_refetch: got %b expected %b", outs, exp); end
        fetch_and_decode(FBranch);
        exp = OPcWe | ORetire; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL beq_not_taken_exec: got %b expected %b", outs, exp); end
        next_cycle();
        exp = OImemReq; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL beq_not_taken_refetch: got %b expected %b", outs, exp); end
    endtask

    task automatic test_load();
        reset_dut();
        fetch_and_decode(FLoad);
        exp = OB; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL lw_exec: got %b expected %b", outs, exp); end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            exp = ODmemReq | OB; #1; n_checks++;
            if (outs !== exp) begin n_errors++; $display("FAIL lw_mem[%0d]: got %b expected %b", i, outs, exp); end
            next_cycle();
        end
        dmem_ack = 1'b0;
        exp = OWbRet | wbs(2'd1); #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL lw_wb: got %b expected %b", outs, exp); end
        next_cycle();
        exp = OImemReq; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL lw_refetch: got %b expected %b", outs, exp); end
    endtask

    task automatic test_store();
        reset_dut();
        fetch_and_decode(FStore);
        exp = OB; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL sw_exec: got %b expected %b", outs, exp); end
        next_cycle();
        dmem_ack = 1'b1;
        exp = ODmemReq | ODmemWe | OB | OPcWe | ORetire; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL sw_mem: got %b expected %b", outs, exp); end
        next_cycle();
        dmem_ack = 1'b0;
        exp = OImemReq; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL sw_refetch: got %b expected %b", outs, exp); end
    endtask

    task automatic test_imem_timeout();
        reset_dut();
        // Ack in the 16th waiting cycle beats the timeout.
        for (int i = 0; i < 15; i++) begin
            exp = OImemReq; #1; n_checks++;
            if (outs !== exp) begin n_errors++; $display("FAIL fetch_wait[%0d]: got %b expected %b", i, outs, exp); end
            next_cycle();
        end
        imem_ack = 1'b1;
        exp = OImemReq | OIrWe; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL fetch_ack_wins: got %b expected %b", outs, exp); end
        next_cycle();
        imem_ack = 1'b0;
        flags = FOp;
        exp = '0; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL fetch_ack_wins_decode: got %b expected %b", outs, exp); end
        repeat (3) next_cycle();
        // Counter restarted: the next fetch traps after exactly 16 cycles.
        for (int i = 0; i < 16; i++) begin
            exp = OImemReq; #1; n_checks++;
            if (outs !== exp) begin n_errors++; $display("FAIL fetch_timeout_wait[%0d]: got %b expected %b", i, outs, exp); end
            next_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            exp = OTrap | cau(2'd2); #1; n_checks++;
            if (outs !== exp) begin n_errors++; $display("FAIL imem_trap[%0d]: got %b expected %b", i, outs, exp); end
            next_cycle();
        end
        reset_dut();
        exp = OImemReq; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL imem_trap_reset: got %b expected %b", outs, exp); end
    endtask

    task automatic test_dmem_timeout();
        reset_dut();
        fetch_and_decode(FLoad);
        next_cycle();
        for (int i = 0; i < 16; i++) begin
            exp = ODmemReq | OB; #1; n_checks++;
            if (outs !== exp) begin n_errors++; $display("FAIL dmem_wait[%0d]: got %b expected %b", i, outs, exp); end
            next_cycle();
        end
        exp = OTrap | cau(2'd3); #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL dmem_trap: got %b expected %b", outs, exp); end
    endtask

    task automatic test_illegal();
        logic [9:0] bad [2];
        bad = '{10'b0, FOp | FLoad};
        for (int i = 0; i < 2; i++) begin
            reset_dut();
            imem_ack = 1'b1;
            next_cycle();
            imem_ack = 1'b0;
            flags = bad[i];
            exp = '0; #1; n_checks++;
            if (outs !== exp) begin n_errors++; $display("FAIL illegal_decode[%0d]: got %b expected %b", i, outs, exp); end
            next_cycle();
            for (int k = 0; k < 3; k++) begin
                imem_ack = 1'b1;
                exp = OTrap | cau(2'd1); #1; n_checks++;
                if (outs !== exp) begin n_errors++; $display("FAIL illegal_trap[%0d.%0d]: got %b expected %b", i, k, outs, exp); end
                next_cycle();
            end
        end
    endtask

    task automatic test_halt();
        reset_dut();
        fetch_and_decode(FSystem);
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0];
            dmem_ack = !i[0];
            exp = OHalted; #1; n_checks++;
            if (outs !== exp) begin n_errors++; $display("FAIL halt_hold[%0d]: got %b expected %b", i, outs, exp); end
            next_cycle();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n = 1'b0;
        exp = '0; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL halt_reset_asserted: got %b expected %b", outs, exp); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp = OImemReq; #1; n_checks++;
        if (outs !== exp) begin n_errors++; $display("FAIL halt_reset_release: got %b expected %b", outs, exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_addi();
        test_alu_classes();
        test_branch();
        test_load();
        test_store();
        test_imem_timeout();
        test_dmem_timeout();
        test_illegal();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
